// File: rtl/tick_timebase.sv
// Programmable prescaler: emits a one-cycle tick every div counted cycles, with
// run/stop, pause, clear, runtime divisor load, one-shot mode and a wrapping tick count.
module tick_timebase #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 5000000,
    parameter int unsigned TICK_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    input  logic              clr,
    input  logic              oneshot,
    input  logic              div_load,
    input  logic [WIDTH-1:0]  div_in,
    output logic              tick,
    output logic              busy,
    output logic [WIDTH-1:0]  phase,
    output logic [TICK_W-1:0] ticks
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0]  PHASE_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0]  DIV_RST   = WIDTH'(DEFAULT_DIV);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic [0:0]        state_q, state_d;
    logic [WIDTH-1:0]  phase_q, phase_d;
    logic [WIDTH-1:0]  div_q,   div_d;
    logic [TICK_W-1:0] ticks_q, ticks_d;
    logic              mode_q,  mode_d;
    logic              tick_q,  tick_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        div_d   = div_q;
        ticks_d = ticks_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
            phase_d = PHASE_ONE;
            ticks_d = '0;
            mode_d  = oneshot;
        end else if (clr) begin
            phase_d = PHASE_ONE;
            ticks_d = '0;
        end else if (div_load) begin
            div_d   = (div_in == '0) ? PHASE_ONE : div_in;
            phase_d = PHASE_ONE;
        end else if (state_q == ST_RUN && en) begin
            // >= keeps a divisor lowered below the current phase from running away
            if (phase_q >= div_q) begin
                tick_d  = 1'b1;
                phase_d = PHASE_ONE;
                ticks_d = ticks_q + TICK_ONE;
                if (mode_q) begin
                    state_d = ST_IDLE;
                end
            end else begin
                phase_d = phase_q + PHASE_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= PHASE_ONE;
            div_q   <= DIV_RST;
            ticks_q <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            ticks_q <= ticks_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign busy  = (state_q == ST_RUN);
    assign phase = phase_q;
    assign ticks = ticks_q;

endmodule

// File: tb/tb_tick_timebase.sv
// Scenario bench for tick_timebase: two instances (16-bit and 2-bit tick counters)
// share stimulus and are compared against a cycle-level reference of the timebase rules.
module tb_tick_timebase;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, stop = 1'b0, en = 1'b0, clr = 1'b0;
    logic         oneshot = 1'b0, div_load = 1'b0;
    logic [W-1:0] div_in = '0;

    logic         tick_a, busy_a, tick_b, busy_b;
    logic [W-1:0] phase_a, phase_b;
    logic [15:0]  ticks_a;
    logic [1:0]   ticks_b;

    int vectors = 0;
    int miscompares = 0;

    // reference state: ticks kept unbounded, reduced modulo the counter width on compare
    logic m_run, m_mode, m_tick;
    int   m_phase, m_div, m_ticks;

    tick_timebase #(.WIDTH(W), .DEFAULT_DIV(4), .TICK_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .clr(clr),
        .oneshot(oneshot), .div_load(div_load), .div_in(div_in),
        .tick(tick_a), .busy(busy_a), .phase(phase_a), .ticks(ticks_a)
    );

    tick_timebase #(.WIDTH(W), .DEFAULT_DIV(4), .TICK_W(2)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .clr(clr),
        .oneshot(oneshot), .div_load(div_load), .div_in(div_in),
        .tick(tick_b), .busy(busy_b), .phase(phase_b), .ticks(ticks_b)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_run = 1'b0; m_mode = 1'b0; m_tick = 1'b0;
        m_phase = 1; m_div = 4; m_ticks = 0;
    endfunction

    // One rising edge of the timebase rules, highest-priority event first.
    function automatic void model_edge();
        logic fire;
        fire = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (stop) m_run = 1'b0;
        else if (start) begin
            m_run = 1'b1; m_phase = 1; m_ticks = 0; m_mode = oneshot;
        end else if (clr) begin
            m_phase = 1; m_ticks = 0;
        end else if (div_load) begin
            m_div = (int'(div_in) == 0) ? 1 : int'(div_in);
            m_phase = 1;
        end else if (m_run && en) begin
            if (m_phase >= m_div) begin
                fire = 1'b1; m_phase = 1; m_ticks = m_ticks + 1;
                if (m_mode) m_run = 1'b0;
            end else m_phase = m_phase + 1;
        end
        m_tick = fire;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; stop = 1'b0; clr = 1'b0; div_load = 1'b0; oneshot = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) clk_step();
        vectors++; if (tick_a !== 1'b0) begin miscompares++; $display("FAIL reset.tick got %b want 0", tick_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset.busy got %b want 0", busy_a); end
        vectors++; if (phase_a !== 8'd1) begin miscompares++; $display("FAIL reset.phase got %0d want 1", phase_a); end
        vectors++; if (ticks_a !== 16'd0) begin miscompares++; $display("FAIL reset.ticks got %0d want 0", ticks_a); end
        rst = 1'b0;
        en = 1'b1;
        repeat (6) begin
            clk_step();
            vectors++; if (tick_a !== 1'b0 || busy_a !== 1'b0 || phase_a !== 8'd1) begin
                miscompares++; $display("FAIL reset.idle got tick=%b busy=%b phase=%0d want 0/0/1", tick_a, busy_a, phase_a);
            end
        end
    endtask

    task automatic test_periodic();
        clear_inputs(); en = 1'b1; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            clk_step();
            vectors++; if (tick_a !== ((k % 4) == 0)) begin miscompares++; $display("FAIL periodic.tick k=%0d got %b want %b", k, tick_a, (k % 4) == 0); end
            vectors++; if (phase_a !== 8'(m_phase) || ticks_a !== 16'(m_ticks) || ticks_b !== 2'(m_ticks)) begin
                miscompares++; $display("FAIL periodic.state k=%0d got phase=%0d ticks=%0d/%0d want %0d/%0d", k, phase_a, ticks_a, ticks_b, m_phase, m_ticks);
            end
        end
        vectors++; if (ticks_a !== 16'd5) begin miscompares++; $display("FAIL periodic.count got %0d want 5", ticks_a); end
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL periodic.busy got %b want 1", busy_a); end
    endtask

    task automatic test_oneshot();
        clear_inputs(); en = 1'b1; oneshot = 1'b1; start = 1'b1;
        clk_step();
        clear_inputs();
        for (int k = 1; k <= 10; k++) begin
            clk_step();
            vectors++; if (tick_a !== (k == 4)) begin miscompares++; $display("FAIL oneshot.tick k=%0d got %b want %b", k, tick_a, k == 4); end
            vectors++; if (busy_a !== (k < 4)) begin miscompares++; $display("FAIL oneshot.busy k=%0d got %b want %b", k, busy_a, k < 4); end
        end
        vectors++; if (phase_a !== 8'd1 || ticks_a !== 16'd1) begin
            miscompares++; $display("FAIL oneshot.final got phase=%0d ticks=%0d want 1/1", phase_a, ticks_a);
        end
    endtask

    task automatic test_pause();
        int tick_at;
        tick_at = -1;
        clear_inputs(); en = 1'b1; start = 1'b1;
        clk_step();
        start = 1'b0;
        clk_step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clk_step();
            vectors++; if (phase_a !== 8'd2 || tick_a !== 1'b0) begin
                miscompares++; $display("FAIL pause.hold got phase=%0d tick=%b want 2/0", phase_a, tick_a);
            end
        end
        en = 1'b1;
        for (int k = 5; k <= 12 && tick_at < 0; k++) begin
            clk_step();
            if (tick_a === 1'b1) tick_at = k;
        end
        vectors++; if (tick_at != 7) begin miscompares++; $display("FAIL pause.resume got tick at edge %0d want 7", tick_at); end
    endtask

    task automatic test_div_load();
        clear_inputs(); en = 1'b1; div_load = 1'b1; div_in = '0;
        clk_step();
        div_load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            clk_step();
            vectors++; if (tick_a !== 1'b1 || phase_a !== 8'd1) begin
                miscompares++; $display("FAIL divzero.tick k=%0d got tick=%b phase=%0d want 1/1", k, tick_a, phase_a);
            end
        end
        div_load = 1'b1; div_in = 8'd3;
        clk_step();
        div_load = 1'b0;
        vectors++; if (phase_a !== 8'd1 || tick_a !== 1'b0) begin
            miscompares++; $display("FAIL div3.load got phase=%0d tick=%b want 1/0", phase_a, tick_a);
        end
        for (int k = 1; k <= 9; k++) begin
            clk_step();
            vectors++; if (tick_a !== ((k % 3) == 0)) begin miscompares++; $display("FAIL div3.tick k=%0d got %b want %b", k, tick_a, (k % 3) == 0); end
        end
    endtask

    task automatic test_wrap_and_stop_start();
        int seq_exp [5];
        int n;
        seq_exp = '{1, 2, 3, 0, 1};
        n = 0;
        clear_inputs(); en = 1'b1; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            clk_step();
            if (tick_b === 1'b1 && n < 5) begin
                vectors++; if (ticks_b !== 2'(seq_exp[n])) begin
                    miscompares++; $display("FAIL wrap.seq n=%0d got %0d want %0d", n, ticks_b, seq_exp[n]);
                end
                n++;
            end
        end
        vectors++; if (n != 5) begin miscompares++; $display("FAIL wrap.count got %0d ticks want 5", n); end
        start = 1'b1; stop = 1'b1;
        clk_step();
        clear_inputs();
        vectors++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            miscompares++; $display("FAIL startstop.busy got %b/%b want 0/0", busy_a, busy_b);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs(); en = 1'b1; start = 1'b1;
        clk_step();
        start = 1'b0;
        repeat (2) clk_step();
        vectors++; if (phase_a !== 8'd3) begin miscompares++; $display("FAIL areset.pre got phase=%0d want 3", phase_a); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        vectors++; if (tick_a !== 1'b0 || busy_a !== 1'b0 || phase_a !== 8'd1 || ticks_a !== 16'd0) begin
            miscompares++; $display("FAIL areset.now got tick=%b busy=%b phase=%0d ticks=%0d want 0/0/1/0", tick_a, busy_a, phase_a, ticks_a);
        end
        repeat (2) clk_step();
        rst = 1'b0;
        clk_step();
        vectors++; if (tick_a !== 1'b0 || busy_a !== 1'b0) begin
            miscompares++; $display("FAIL areset.release got tick=%b busy=%b want 0/0", tick_a, busy_a);
        end
        start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            clk_step();
            vectors++; if (tick_a !== ((k % 4) == 0)) begin miscompares++; $display("FAIL areset.div k=%0d got %b want %b", k, tick_a, (k % 4) == 0); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            stop     = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 29) == 0);
            clr      = ($urandom_range(0, 49) == 0);
            div_load = ($urandom_range(0, 39) == 0);
            div_in   = 8'($urandom_range(0, 7));
            oneshot  = ($urandom_range(0, 3) == 0);
            en       = ($urandom_range(0, 4) != 0);
            clk_step();
            vectors++; if (tick_a !== m_tick || busy_a !== m_run) begin
                miscompares++; $display("FAIL random.ctl k=%0d got tick=%b busy=%b want %b/%b", k, tick_a, busy_a, m_tick, m_run);
            end
            vectors++; if (phase_a !== 8'(m_phase) || ticks_a !== 16'(m_ticks) || ticks_b !== 2'(m_ticks)) begin
                miscompares++; $display("FAIL random.state k=%0d got phase=%0d ticks=%0d/%0d want %0d/%0d", k, phase_a, ticks_a, ticks_b, m_phase, m_ticks);
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_pause();
        test_div_load();
        test_wrap_and_stop_start();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
